// File: rtl/sample_stream_memory.sv
// Multi-channel sample store with a random-access write port, a registered read port
// and a valid/ready burst streamer that replays a contiguous address range.
module sample_stream_memory #(
  parameter int unsigned DW    = 20,
  parameter int unsigned CH    = 2,
  parameter int unsigned DEPTH = 150,
  parameter int unsigned BASE  = 106,
  parameter int unsigned AW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [CH*DW-1:0]   wr_data,
  output logic               wr_err,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [CH*DW-1:0]   rd_data,
  output logic               rd_valid,
  output logic               rd_err,
  input  logic               start,
  input  logic [AW-1:0]      s_first,
  input  logic [AW-1:0]      s_len,
  output logic               busy,
  output logic               s_valid,
  input  logic               s_ready,
  output logic [CH*DW-1:0]   s_data,
  output logic               s_last,
  output logic               done,
  output logic               start_err
);

  localparam int unsigned EW  = CH * DW;
  localparam int unsigned LIM = BASE + DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Range test done with a borrow bit so no comparison is constant for any parameter set.
  function automatic logic in_range(input logic [AW-1:0] addr);
    logic [AW+1:0] diff;
    diff = (AW+2)'(addr) - (AW+2)'(BASE);
    return !diff[AW+1] && (diff[AW:0] < (AW+1)'(DEPTH));
  endfunction

  logic [EW-1:0] mem_q [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          s_valid_q, s_valid_d;
  logic [EW-1:0] s_data_q, s_data_d;
  logic          s_last_q, s_last_d;
  logic          done_q, done_d;
  logic          start_err_q, start_err_d;
  logic          wr_err_q, wr_err_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_err_q, rd_err_d;
  logic [EW-1:0] rd_data_q, rd_data_d;

  logic          wr_ok_c, rd_ok_c, first_ok_c, end_over_c;
  logic [AW-1:0] wr_idx_c, rd_idx_c, first_idx_c;
  logic [AW:0]   end_c;

  assign wr_ok_c     = in_range(wr_addr);
  assign rd_ok_c     = in_range(rd_addr);
  assign first_ok_c  = in_range(s_first);
  assign wr_idx_c    = AW'(wr_addr - AW'(BASE));
  assign rd_idx_c    = AW'(rd_addr - AW'(BASE));
  assign first_idx_c = AW'(s_first - AW'(BASE));
  assign end_c       = (AW+1)'(s_first) + (AW+1)'(s_len);
  assign end_over_c  = end_c > (AW+1)'(LIM);

  // Storage is never reset; all reads sample mem_q before this edge's write (read-first).
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok_c) begin
      mem_q[wr_idx_c] <= wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    s_valid_d   = s_valid_q;
    s_data_d    = s_data_q;
    s_last_d    = s_last_q;
    done_d      = 1'b0;
    start_err_d = 1'b0;
    wr_err_d    = wr_en && !wr_ok_c;
    rd_valid_d  = 1'b0;
    rd_err_d    = 1'b0;
    rd_data_d   = rd_data_q;

    if (rd_en) begin
      if (!busy_q && rd_ok_c) begin
        rd_valid_d = 1'b1;
        rd_data_d  = mem_q[rd_idx_c];
      end else begin
        rd_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (s_len == '0) begin
            done_d = 1'b1;
          end else if (!first_ok_c || end_over_c) begin
            start_err_d = 1'b1;
          end else begin
            ptr_d   = first_idx_c;
            rem_d   = s_len;
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Final beat accepted: close the burst and signal completion next cycle.
        if (s_valid_q && s_ready && (rem_q == '0)) begin
          s_valid_d = 1'b0;
          s_last_d  = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_DONE;
        end else if ((!s_valid_q || s_ready) && (rem_q != '0)) begin
          s_data_d  = mem_q[ptr_q];
          s_valid_d = 1'b1;
          s_last_d  = (rem_q == AW'(1));
          ptr_d     = ptr_q + AW'(1);
          rem_d     = rem_q - AW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      s_valid_q   <= 1'b0;
      s_data_q    <= '0;
      s_last_q    <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
      s_last_q    <= s_last_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      wr_err_q    <= wr_err_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign wr_err    = wr_err_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign busy      = busy_q;
  assign s_valid   = s_valid_q;
  assign s_data    = s_data_q;
  assign s_last    = s_last_q;
  assign done      = done_q;
  assign start_err = start_err_q;

endmodule
